// File: rtl/fetch_pkg.sv
// Shared types and helpers for the IF stage: fetch-queue entry, opcodes, immediate extractors.
// FETCH_BTFN_EN (in fetch_unit) selects the optional backward-taken/forward-not-taken predecode.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned ILEN         = 32;

  localparam logic [ILEN-1:0] NOP_BUBBLE = 32'h0;
  localparam logic [6:0]      OPC_JAL    = 7'b1101111;
  localparam logic [6:0]      OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN-1:0]         instr;
    logic                    pred;
  } fetch_entry_t;

  // J-type immediate from instr[31:12]
  function automatic logic [31:0] imm_j(input logic [19:0] hi);
    return {{12{hi[19]}}, hi[7:0], hi[8], hi[18:9], 1'b0};
  endfunction

  // B-type immediate from instr[31:25] and instr[11:7]
  function automatic logic [31:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
    return {{20{hi[6]}}, lo[0], hi[5:0], lo[4:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with a clear input; head is read straight from storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC generator, 1-cycle imem port, epoch-tagged in-flight slot and fetch queue toward ID.
// Optional static prediction of JAL / backward branches when FETCH_BTFN_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  input  logic            id_flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic            id_pred_taken
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0]  pc_q;
  logic             epoch_q;
  logic             infl_vld_q;
  logic             infl_epoch_q;
  logic [XLEN-1:0]  infl_pc_q;

  logic [CNT_W-1:0] fq_count;
  logic [CNT_W:0]   fill;
  fetch_entry_t     fq_head;
  fetch_entry_t     fq_push_data;
  logic             kill;
  logic             issue;
  logic             push;
  logic             pop;
  logic             pred_c;
  logic             pred_take;
  logic [XLEN-1:0]  pred_tgt;

  assign kill  = ex_redirect | id_flush;
  assign fill  = {1'b0, fq_count} + (CNT_W+1)'(infl_vld_q);
  // Credit rule: queued + in-flight never exceeds depth, so a response always has a slot
  assign issue = rst_n & ~ex_redirect & (fill < (CNT_W+1)'(FQ_DEPTH));
  assign push  = infl_vld_q & (infl_epoch_q == epoch_q) & ~kill;
  assign pop   = id_valid & id_ready & ~kill;

`ifdef FETCH_BTFN_EN
  logic        is_jal;
  logic        is_br;
  logic [31:0] imm;

  assign is_jal    = (imem_rdata[6:0] == OPC_JAL);
  assign is_br     = (imem_rdata[6:0] == OPC_BRANCH);
  assign imm       = is_jal ? imm_j(imem_rdata[31:12]) : imm_b(imem_rdata[31:25], imem_rdata[11:7]);
  assign pred_c    = is_jal | (is_br & imm[31]);
  assign pred_take = push & pred_c;
  assign pred_tgt  = infl_pc_q + XLEN'($signed(imm));
`else
  assign pred_c    = 1'b0;
  assign pred_take = 1'b0;
  assign pred_tgt  = '0;
`endif

  assign fq_push_data = '{pc: XLEN_DEFAULT'(infl_pc_q), instr: imem_rdata, pred: pred_c};

  assign imem_req      = issue;
  assign imem_addr     = pc_q;
  assign id_valid      = (fq_count != '0);
  assign id_pc         = id_valid ? XLEN'(fq_head.pc) : '0;
  assign id_instr      = id_valid ? fq_head.instr : NOP_BUBBLE;
  assign id_pred_taken = id_valid & fq_head.pred;

  // Requests issued during a flush belong to the new stream; those beside a prediction do not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      epoch_q      <= 1'b0;
      infl_vld_q   <= 1'b0;
      infl_epoch_q <= 1'b0;
      infl_pc_q    <= '0;
    end else begin
      if (ex_redirect)    pc_q <= ex_target & ~XLEN'(3);
      else if (pred_take) pc_q <= pred_tgt;
      else if (issue)     pc_q <= pc_q + XLEN'(4);
      epoch_q      <= epoch_q ^ (kill | pred_take);
      infl_vld_q   <= issue;
      infl_epoch_q <= epoch_q ^ id_flush;
      if (issue) infl_pc_q <= pc_q;
    end
  end

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (kill),
    .push      (push),
    .push_data (fq_push_data),
    .pop       (pop),
    .head      (fq_head),
    .count     (fq_count)
  );

endmodule
